// File: rtl/up_down_counter_if.sv
// Interface bundling the counter's direction input with its count/terminal-count outputs.
// The master side drives the direction and observes the count; the slave is the counter.
interface up_down_counter_if #(
  parameter int WIDTH = 3
);

  logic             up_down;  // 1 = count up, 0 = count down
  logic [WIDTH-1:0] count;    // registered counter value
  logic             tc;       // terminal count: next edge wraps

  modport master (
    output up_down,
    input  count,
    input  tc
  );

  modport slave (
    input  up_down,
    output count,
    output tc
  );

endinterface : up_down_counter_if

// File: rtl/up_down_counter.sv
// Free-running modulo-2^WIDTH up/down counter.
// Steps once per rising clock edge in the direction given by up_down.
// tc flags the cycle in which the next edge will wrap, for cascading.
module up_down_counter #(
  parameter int          WIDTH       = 3,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic               clk,
  input  logic               reset,  // asynchronous, active-low
  up_down_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] RST_VAL   = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: one step up or down; natural WIDTH-bit overflow gives the wrap.
  always_comb begin
    // NOTE: default assigned first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (bus.up_down) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q - ONE;
    end
  end

  // Count register: reset value loaded asynchronously, otherwise steps every edge.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignment so all flops update together from pre-edge values.
    if (!reset) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count follows up_down combinationally so a direction change is seen at once.
  always_comb begin
    bus.tc = 1'b0;
    if (bus.up_down && (count_q == MAX_COUNT)) begin
      bus.tc = 1'b1;
    end else if (!bus.up_down && (count_q == '0)) begin
      bus.tc = 1'b1;
    end
  end

  assign bus.count = count_q;

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter (WIDTH=3, RESET_VALUE=0).
// A modulo-arithmetic model is compared with the DUT on every falling edge;
// directed steps also carry hand-computed literal expectations.
module tb_up_down_counter;

  localparam int WIDTH = 3;
  localparam int MOD   = 1 << WIDTH;
  localparam int RST   = 0;

  logic clk;
  logic reset;

  up_down_counter_if #(.WIDTH(WIDTH)) bus ();

  up_down_counter #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;
  int exp_count = RST;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain modular arithmetic on an integer.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_count = RST;
    else        exp_count = (exp_count + (bus.up_down ? 1 : MOD - 1)) % MOD;
  end

  // Compare process: every falling edge once the model is valid.
  always @(negedge clk) begin
    if (compare_en) begin
      check("model_count", int'(bus.count), exp_count);
      check("model_tc", int'(bus.tc),
            ((bus.up_down && exp_count == MOD - 1) || (!bus.up_down && exp_count == 0)) ? 1 : 0);
    end
  end

  // Apply a direction, let one rising edge pass, then settle just after it.
  task automatic step(input logic ud);
    bus.up_down = ud;
    @(posedge clk);
    #1;
  endtask

  task automatic step_expect(input logic ud, input int exp_c, input string name);
    step(ud);
    check(name, int'(bus.count), exp_c);
  endtask

  initial begin
    reset = 1'b1;
    bus.up_down = 1'b1;
    #1;
    // Reset applied with no clock edge yet.
    reset = 1'b0;
    #1;
    check("reset_async_count", int'(bus.count), 0);
    check("reset_async_tc", int'(bus.tc), 0);
    compare_en = 1'b1;
    // Hold reset across two edges.
    step(1'b1);
    step(1'b1);
    check("reset_hold_count", int'(bus.count), 0);

    // Release between edges; counting starts on the next edge.
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) step_expect(1'b1, i, "count_up");

    // Count down from 5 to 0.
    for (int i = 4; i >= 0; i--) step_expect(1'b0, i, "count_down");
    check("tc_at_zero_down", int'(bus.tc), 1);

    // Mid-count reset returns to 0 without a clock edge.
    step_expect(1'b1, 1, "pre_reset_up");
    step_expect(1'b1, 2, "pre_reset_up");
    step_expect(1'b1, 3, "pre_reset_up");
    reset = 1'b0;
    #1;
    check("mid_reset_async", int'(bus.count), 0);
    step(1'b1);
    check("mid_reset_hold", int'(bus.count), 0);
    reset = 1'b1;

    // Wrap up: climb to 6, then 7 (tc) -> 0 -> 1.
    for (int i = 1; i <= 6; i++) step_expect(1'b1, i, "climb");
    step_expect(1'b1, 7, "wrap_up_7");
    check("wrap_up_tc7", int'(bus.tc), 1);
    step_expect(1'b1, 0, "wrap_up_0");
    check("wrap_up_tc0", int'(bus.tc), 0);
    step_expect(1'b1, 1, "wrap_up_1");

    // Wrap down: 1 -> 0 (tc) -> 7 -> 6.
    step_expect(1'b0, 0, "wrap_dn_0");
    check("wrap_dn_tc0", int'(bus.tc), 1);
    step_expect(1'b0, 7, "wrap_dn_7");
    check("wrap_dn_tc7", int'(bus.tc), 0);
    step_expect(1'b0, 6, "wrap_dn_6");

    // Down to 3, then toggle direction every cycle.
    step_expect(1'b0, 5, "to_three");
    step_expect(1'b0, 4, "to_three");
    step_expect(1'b0, 3, "to_three");
    step_expect(1'b1, 4, "toggle");
    step_expect(1'b0, 3, "toggle");
    step_expect(1'b1, 4, "toggle");
    step_expect(1'b0, 3, "toggle");

    // tc follows up_down combinationally at count 7.
    for (int i = 4; i <= 7; i++) step_expect(1'b1, i, "to_seven");
    bus.up_down = 1'b1;
    #1;
    check("tc_comb_up", int'(bus.tc), 1);
    bus.up_down = 1'b0;
    #1;
    check("tc_comb_down", int'(bus.tc), 0);
    check("tc_comb_count_stable", int'(bus.count), 7);
    step_expect(1'b0, 6, "after_comb");

    // Long mixed run left to the model.
    for (int i = 0; i < 40; i++) step(logic'((i % 7) < 4));

    compare_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_up_down_counter
